wb_stage_reg: RTL and testbench
===============================

// Module: wb_stage_reg
// PURPOSE
//   Registered write-back stage of the pipelined RISC core; replaces the 2:1 write-back mux.
//   Latches MEM-stage results and selects one of four sources: ALU, memory, PC+4, immediate.
//   Drives the register-file write port with a one-cycle latency.
//   Honours pipeline stall and flush, and counts retired register writes.
// PARAMETERS
//   DATA_W      32  width of every data source and of wb_data
//   REG_ADDR_W  5   register-file address width
//   ZERO_REG    1   1: writes to register 0 are suppressed; 0: register 0 is writable
//   CNT_W       32  width of the retired-write counter
// PORTS
//   clk          in   1           clock; all state updates on the rising edge
//   rst          in   1           synchronous reset, active-high
//   in_valid     in   1           MEM stage presents a valid instruction
//   stall        in   1           hold the stage contents
//   flush        in   1           discard the incoming instruction and the held instruction
//   reg_write    in   1           instruction writes the register file
//   rd_addr      in   REG_ADDR_W  destination register
//   wb_sel       in   2           source select: 0 ALU, 1 MEM, 2 PC+4, 3 IMM
//   alu_data     in   DATA_W      ALU result
//   mem_data     in   DATA_W      raw data-memory read word
//   pc_plus4     in   DATA_W      link address
//   imm_data     in   DATA_W      immediate, used by LUI-type instructions
//   mem_size     in   2           0 byte, 1 half, 2 word (used only with WB_LOAD_EXT_EN)
//   mem_unsigned in   1           1: zero-extend; 0: sign-extend (WB_LOAD_EXT_EN only)
//   byte_off     in   2           address[1:0] of the load (WB_LOAD_EXT_EN only)
//   wb_valid     out  1           stage holds a valid instruction
//   wb_en        out  1           register-file write strobe
//   wb_addr      out  REG_ADDR_W  register-file write address
//   wb_data      out  DATA_W      register-file write data
//   wb_count     out  CNT_W       number of wb_en pulses since reset
// BEHAVIOUR
//   - Reset: wb_valid=0, wb_en=0, wb_addr=0, wb_data=0, wb_count=0, internal 'done' flag=0.
//   - Source select is combinational on the inputs; the selected value is registered.
//   - Latency: inputs on edge N appear on wb_* after edge N; one instruction per cycle.
//   - Priority: rst > flush > stall > load.
//   - flush=1: next cycle wb_valid=0 and wb_en=0. wb_addr/wb_data are don't-care; hold them.
//   - stall=1 (no flush): all registers hold and inputs are ignored.
//       - wb_en is high only in the first cycle an entry is presented.
//       - 'done' is set after that cycle and cleared on the next load.
//       - Each instruction writes exactly once, however long the stall lasts.
//   - Load (no stall, no flush): wb_valid<=in_valid; wb_addr<=rd_addr; wb_data<=selected source; done<=0.
//   - wb_en = wb_valid & reg_write_q & ~done & ~(ZERO_REG && wb_addr==0). This is a registered-state decode.
//   - in_valid=0 loads a bubble: wb_valid=0 and wb_en=0.
//   - wb_count increments by 1 on every cycle with wb_en=1 and wraps modulo 2^CNT_W.
//   - rst asserted mid-stall clears everything at the next edge; no pending write survives.
//   - Reset behaves as a flush that also clears wb_count.
//   - stall and flush both high: flush wins and the held entry is discarded.
// CONFIGURATION
//   WB_LOAD_EXT_EN defined:
//     - When wb_sel=1, the byte or half lane at byte_off is extracted from mem_data.
//       byte: lane = byte_off; half: lane = byte_off[1].
//     - The lane is zero-extended (mem_unsigned=1) or sign-extended (mem_unsigned=0) to DATA_W.
//     - mem_size=2 or 3 passes the word unchanged.
//   WB_LOAD_EXT_EN undefined:
//     - mem_data is passed unchanged.
//     - mem_size, mem_unsigned and byte_off are ignored (left unconnected internally).
// TESTING
//   1. rst=1 for 2 cycles -> every output 0; wb_count=0.
//   2. in_valid=1, reg_write=1, rd=5, wb_sel=0, alu=0x1234 -> next cycle wb_en=1, addr=5, data=0x1234, count=1.
//   3. Write to rd=0 with ZERO_REG=1 -> wb_valid=1, wb_en=0, count unchanged; with ZERO_REG=0 -> wb_en=1.
//   4. Load entry, then stall=1 for 3 cycles -> wb_en high in cycle 1 only.
//      Data held throughout; count increments by exactly 1.
//   5. stall=1 and flush=1 together -> next cycle wb_valid=0 and wb_en=0.
//      Then stall=0 with a new entry loads normally.
//   6. WB_LOAD_EXT_EN: mem=0x80FF7F01, wb_sel=1:
//        byte, off=3, signed   -> 0xFFFFFF80
//        half, off=2, unsigned -> 0x000080FF
//        word                  -> 0x80FF7F01
//      Without the macro: all three cases -> 0x80FF7F01.

Source files
------------

// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM-stage payload in, register-file write port out.
// Parameters must match the wb_stage_reg instance that binds the slave modport.
interface wb_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  // Handshake: in_valid qualifies the MEM payload on every rising edge. There is
  // no ready; stall is the back-pressure (payload ignored while high) and flush
  // kills both the incoming and the held instruction. wb_en is a one-shot strobe
  // per held instruction, and wb_valid only says the stage holds an instruction.
  logic                  in_valid;
  logic                  stall;
  logic                  flush;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [1:0]            wb_sel;
  logic [DATA_W-1:0]     alu_data;
  logic [DATA_W-1:0]     mem_data;
  logic [DATA_W-1:0]     pc_plus4;
  logic [DATA_W-1:0]     imm_data;
  logic [1:0]            mem_size;
  logic                  mem_unsigned;
  logic [1:0]            byte_off;
  logic                  wb_valid;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic [CNT_W-1:0]      wb_count;

  modport master (
    output in_valid, stall, flush, reg_write, rd_addr, wb_sel,
    output alu_data, mem_data, pc_plus4, imm_data,
    output mem_size, mem_unsigned, byte_off,
    input  wb_valid, wb_en, wb_addr, wb_data, wb_count
  );

  modport slave (
    input  in_valid, stall, flush, reg_write, rd_addr, wb_sel,
    input  alu_data, mem_data, pc_plus4, imm_data,
    input  mem_size, mem_unsigned, byte_off,
    output wb_valid, wb_en, wb_addr, wb_data, wb_count
  );
endinterface

// File: rtl/wb_stage_reg.sv
// Registered write-back stage: 4-way source select, stall/flush, one write per instruction.
// Define WB_LOAD_EXT_EN to extract and sign/zero-extend byte and half loads from mem_data.
module wb_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  logic                  valid_q;
  logic                  rw_q;
  logic                  done_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0]     data_q;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_W-1:0]     load_data;
  logic [DATA_W-1:0]     sel_data;
  logic                  en;

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = bus.mem_data[7:0];
    lane_h    = bus.mem_data[15:0];
    load_data = bus.mem_data;
    case (bus.byte_off)
      2'd1:    lane_b = bus.mem_data[15:8];
      2'd2:    lane_b = bus.mem_data[23:16];
      2'd3:    lane_b = bus.mem_data[31:24];
      default: lane_b = bus.mem_data[7:0];
    endcase
    if (bus.byte_off[1]) lane_h = bus.mem_data[31:16];
    case (bus.mem_size)
      2'd0:    load_data = {{(DATA_W-8){~bus.mem_unsigned & lane_b[7]}}, lane_b};
      2'd1:    load_data = {{(DATA_W-16){~bus.mem_unsigned & lane_h[15]}}, lane_h};
      default: load_data = bus.mem_data;
    endcase
  end
`else
  // Load-shaping controls have no effect when extension is compiled out.
  logic unused_load_ctl;
  assign unused_load_ctl = ^{bus.mem_size, bus.mem_unsigned, bus.byte_off};
  assign load_data = bus.mem_data;
`endif

  always_comb begin
    sel_data = bus.alu_data;
    case (bus.wb_sel)
      2'd1:    sel_data = load_data;
      2'd2:    sel_data = bus.pc_plus4;
      2'd3:    sel_data = bus.imm_data;
      default: sel_data = bus.alu_data;
    endcase
  end

  // done_q blocks a second strobe while a stalled instruction sits in the stage.
  assign en = valid_q & rw_q & ~done_q &
              ~((ZERO_REG != 0) && (addr_q == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rw_q    <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      if (en) count_q <= count_q + CNT_W'(1);
      if (bus.flush) begin
        valid_q <= 1'b0;
        done_q  <= 1'b0;
      end else if (bus.stall) begin
        done_q  <= 1'b1;
      end else begin
        valid_q <= bus.in_valid;
        rw_q    <= bus.reg_write;
        addr_q  <= bus.rd_addr;
        data_q  <= sel_data;
        done_q  <= 1'b0;
      end
    end
  end

  assign bus.wb_valid = valid_q;
  assign bus.wb_en    = en;
  assign bus.wb_addr  = addr_q;
  assign bus.wb_data  = data_q;
  assign bus.wb_count = count_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Bench for wb_stage_reg: ZERO_REG=1 and ZERO_REG=0 instances share one stimulus stream,
// checked every cycle against an entry-level model plus hand-computed literals.
module tb_wb_stage_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 32;
  localparam int W  = AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 0, stall = 0, flush = 0, reg_write = 0, mem_unsigned = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]    wb_sel = '0, mem_size = '0, byte_off = '0;
  logic [DW-1:0] alu_data = '0, mem_data = '0, pc_plus4 = '0, imm_data = '0;

  wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus1 ();
  wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) bus0 ();

  assign bus1.in_valid = in_valid;     assign bus0.in_valid = in_valid;
  assign bus1.stall = stall;           assign bus0.stall = stall;
  assign bus1.flush = flush;           assign bus0.flush = flush;
  assign bus1.reg_write = reg_write;   assign bus0.reg_write = reg_write;
  assign bus1.rd_addr = rd_addr;       assign bus0.rd_addr = rd_addr;
  assign bus1.wb_sel = wb_sel;         assign bus0.wb_sel = wb_sel;
  assign bus1.alu_data = alu_data;     assign bus0.alu_data = alu_data;
  assign bus1.mem_data = mem_data;     assign bus0.mem_data = mem_data;
  assign bus1.pc_plus4 = pc_plus4;     assign bus0.pc_plus4 = pc_plus4;
  assign bus1.imm_data = imm_data;     assign bus0.imm_data = imm_data;
  assign bus1.mem_size = mem_size;     assign bus0.mem_size = mem_size;
  assign bus1.mem_unsigned = mem_unsigned; assign bus0.mem_unsigned = mem_unsigned;
  assign bus1.byte_off = byte_off;     assign bus0.byte_off = byte_off;

  wb_stage_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave));
  wb_stage_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .ZERO_REG(0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave));

  int total = 0;
  int bad   = 0;
  bit checking = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: one "entry" per instruction in the stage ----------------
  logic          m_valid = 0, m_rw = 0, m_presented = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  int unsigned   m_cnt1 = 0, m_cnt0 = 0;
  logic [W-1:0]  exp_q[$];

  function automatic logic [DW-1:0] sel_model(input logic [1:0] sel, input logic [1:0] size,
                                              input logic uns, input logic [1:0] off);
    logic [DW-1:0] v;
    case (sel)
      2'd0: v = alu_data;
      2'd2: v = pc_plus4;
      2'd3: v = imm_data;
      default: begin
        v = mem_data;
`ifdef WB_LOAD_EXT_EN
        if (size == 2'd0) begin
          v = (mem_data >> (8 * int'(off))) & 32'hFF;
          if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
          v = (mem_data >> (16 * int'(off[1]))) & 32'hFFFF;
          if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
`else
        if (size == 2'd3 && uns && off == 2'd3) v = mem_data;
`endif
      end
    endcase
    return v;
  endfunction

  // An instruction writes once: only while it has not yet been shown to the register file.
  function automatic logic exp_en(input int z);
    return m_valid && m_rw && !m_presented && !(z != 0 && m_addr == '0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 0; m_rw = 0; m_presented = 0; m_addr = '0; m_data = '0;
      m_cnt1 = 0; m_cnt0 = 0;
    end else begin
      if (exp_en(1)) m_cnt1++;
      if (exp_en(0)) m_cnt0++;
      if (flush) m_valid = 0;
      else if (stall) m_presented = 1;
      else begin
        m_valid = in_valid; m_rw = reg_write; m_addr = rd_addr;
        m_data = sel_model(wb_sel, mem_size, mem_unsigned, byte_off);
        m_presented = 0;
      end
    end
    if (checking && exp_en(1)) exp_q.push_back({m_addr, m_data});
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      chk("valid1", bus1.wb_valid, m_valid);
      chk("en1", bus1.wb_en, exp_en(1));
      chk("count1", bus1.wb_count, m_cnt1);
      chk("valid0", bus0.wb_valid, m_valid);
      chk("en0", bus0.wb_en, exp_en(0));
      chk("count0", bus0.wb_count, m_cnt0);
      if (m_valid) begin
        chk("addr1", bus1.wb_addr, m_addr);
        chk("data1", bus1.wb_data, m_data);
        chk("data0", bus0.wb_data, m_data);
      end
      if (bus1.wb_en) begin
        if (exp_q.size() == 0) chk("sb_unexpected_write", 1, 0);
        else chk("sb_write", {bus1.wb_addr, bus1.wb_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic iv, input logic rw, input logic [AW-1:0] rd,
                     input logic [1:0] sel, input logic [DW-1:0] val);
    in_valid = iv; reg_write = rw; rd_addr = rd; wb_sel = sel;
    alu_data = val; imm_data = val ^ 32'h0F0F_0000; pc_plus4 = val + 4;
  endtask

  initial begin
    @(negedge clk);
    rst = 1; cyc(); cyc();
    chk("rst_valid", bus1.wb_valid, 0);
    chk("rst_en", bus1.wb_en, 0);
    chk("rst_addr", bus1.wb_addr, 0);
    chk("rst_data", bus1.wb_data, 0);
    chk("rst_count", bus1.wb_count, 0);
    rst = 0; checking = 1;

    // basic ALU write
    put(1, 1, 5, 0, 32'h1234); cyc();
    chk("t2_en", bus1.wb_en, 1);
    chk("t2_addr", bus1.wb_addr, 5);
    chk("t2_data", bus1.wb_data, 32'h1234);
    put(0, 0, 0, 0, 0); cyc();
    chk("t2_count", bus1.wb_count, 1);

    // register 0
    put(1, 1, 0, 0, 32'hAA); cyc();
    chk("t3_valid_z1", bus1.wb_valid, 1);
    chk("t3_en_z1", bus1.wb_en, 0);
    chk("t3_en_z0", bus0.wb_en, 1);
    put(0, 0, 0, 0, 0); cyc();
    chk("t3_count_z1", bus1.wb_count, 1);
    chk("t3_count_z0", bus0.wb_count, 2);

    // stall holds, one write only
    put(1, 1, 7, 0, 32'h55AA); cyc();
    chk("t4_en_first", bus1.wb_en, 1);
    stall = 1; put(1, 1, 9, 0, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_en_stalled", bus1.wb_en, 0);
      chk("t4_data_held", bus1.wb_data, 32'h55AA);
      chk("t4_addr_held", bus1.wb_addr, 7);
    end
    stall = 0; put(0, 0, 0, 0, 0); cyc();
    chk("t4_count", bus1.wb_count, 2);

    // stall+flush together
    put(1, 1, 3, 0, 32'h77); cyc();
    chk("t5_en_load", bus1.wb_en, 1);
    stall = 1; flush = 1; cyc();
    chk("t5_valid_flushed", bus1.wb_valid, 0);
    chk("t5_en_flushed", bus1.wb_en, 0);
    stall = 0; flush = 0; put(1, 1, 4, 0, 32'h99); cyc();
    chk("t5_en_reload", bus1.wb_en, 1);
    chk("t5_addr_reload", bus1.wb_addr, 4);
    chk("t5_data_reload", bus1.wb_data, 32'h99);
    chk("t5_count", bus1.wb_count, 3);

    // memory source shaping
    put(1, 1, 10, 1, 0); mem_data = 32'h80FF_7F01;
    mem_size = 0; byte_off = 3; mem_unsigned = 0; cyc();
`ifdef WB_LOAD_EXT_EN
    chk("t6_byte_s", bus1.wb_data, 32'hFFFF_FF80);
`else
    chk("t6_byte_s", bus1.wb_data, 32'h80FF_7F01);
`endif
    mem_size = 1; byte_off = 2; mem_unsigned = 1; cyc();
`ifdef WB_LOAD_EXT_EN
    chk("t6_half_u", bus1.wb_data, 32'h0000_80FF);
`else
    chk("t6_half_u", bus1.wb_data, 32'h80FF_7F01);
`endif
    mem_size = 2; byte_off = 0; mem_unsigned = 0; cyc();
    chk("t6_word", bus1.wb_data, 32'h80FF_7F01);
    put(1, 1, 11, 2, 32'h100); cyc();
    chk("sel_pc", bus1.wb_data, 32'h104);
    put(1, 1, 12, 3, 32'hABCD_0000); cyc();
    chk("sel_imm", bus1.wb_data, 32'hA4C2_0000);

    // reset during a stall
    put(1, 1, 6, 0, 32'h66); cyc();
    chk("rs_en_load", bus1.wb_en, 1);
    stall = 1; rst = 1; cyc();
    chk("rs_valid", bus1.wb_valid, 0);
    chk("rs_en", bus1.wb_en, 0);
    chk("rs_count", bus1.wb_count, 0);
    rst = 0; cyc();
    chk("rs_no_pending", bus1.wb_en, 0);
    stall = 0;

    // mixed vectors, checked by the per-cycle model
    for (int i = 0; i < 60; i++) begin
      put(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), $urandom);
      mem_data = $urandom; mem_size = 2'($urandom_range(0, 3));
      mem_unsigned = 1'($urandom_range(0, 1)); byte_off = 2'($urandom_range(0, 3));
      stall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cyc();
    end
    stall = 0; flush = 0; put(0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("sb_drained", exp_q.size(), 0);

    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
